// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// Frame-control state machine of the UART receiver. It watches the idle-high
// serial line for a start bit, enables the external edge/bit counter for the
// length of one frame, and decodes that counter into one-cycle strobes for the
// sampler, the deserializer and the start/parity/stop checkers. At the end of
// every frame whose stop bit (and parity, when enabled) checked clean it emits
// a one-cycle data_valid pulse.
//
// Parameters
//   DATA_WIDTH      data bits per frame (5..8)
//   PRESCALE_WIDTH  width of Prescale and edge_cnt
//
// Ports
//   CLK          in   oversampling clock
//   RST          in   asynchronous active-low reset
//   RX_IN        in   serial line, idle high
//   PAR_EN       in   frame carries a parity bit (captured at the start bit)
//   Prescale     in   oversampling ratio (8, 16 or 32)
//   bit_cnt      in   bit index inside the frame, start bit = 0
//   edge_cnt     in   oversample tick inside the bit, 0..Prescale-1
//   strt_glitch  in   start checker result (registered)
//   par_err      in   parity checker result (registered)
//   stp_err      in   stop checker result (registered)
//   cnt_enable   out  counter enable, low clears the counter
//   dat_samp_en  out  sampler enable on the three mid-bit ticks
//   deser_en     out  deserializer shift strobe, one per data bit
//   strt_chk_en  out  start-check strobe
//   par_chk_en   out  parity-check strobe
//   stp_chk_en   out  stop-check strobe
//   data_valid   out  one-cycle pulse after an error-free frame
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [3:0]                bit_cnt,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      cnt_enable,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE  = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] EDGE_TWO  = PRESCALE_WIDTH'(2);
    // bit_cnt value of the last data bit (start bit occupies index 0)
    localparam logic [3:0]                LAST_DATA = 4'(DATA_WIDTH);

    state_e state_q;
    state_e state_d;
    logic   par_en_q;
    logic   par_en_d;
    logic   par_err_q;
    logic   par_err_d;
    logic   data_valid_q;
    logic   data_valid_d;

    logic [PRESCALE_WIDTH-1:0] half_s;
    logic                      last_s;
    logic                      samp_win_s;
    logic                      strobe_s;
    logic                      busy_s;

    // Counter decode: half-bit point, last tick of a bit, sampling window, strobe tick
    always_comb begin
        half_s     = {1'b0, Prescale[PRESCALE_WIDTH-1:1]};
        last_s     = (edge_cnt == (Prescale - EDGE_ONE));
        // majority sampling uses the tick before, at and after mid-bit
        samp_win_s = (edge_cnt == (half_s - EDGE_ONE)) ||
                     (edge_cnt == half_s) ||
                     (edge_cnt == (half_s + EDGE_ONE));
        // the sampler's majority result is ready two ticks after mid-bit
        strobe_s   = (edge_cnt == (half_s + EDGE_TWO));
        busy_s     = (state_q != S_IDLE);
    end

    // Next-state, parity-mode capture and data_valid qualification
    always_comb begin
        state_d      = state_q;
        par_en_d     = par_en_q;
        par_err_d    = par_err_q;
        data_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!RX_IN) begin
                    // frame format is frozen here; PAR_EN is ignored until the next start bit
                    state_d   = S_START;
                    par_en_d  = PAR_EN;
                    par_err_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (last_s) begin
                    if (strt_glitch) begin
                        // false start: drop the frame silently
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (last_s && (bit_cnt == LAST_DATA)) begin
                    if (par_en_q) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (last_s) begin
                    // checker result is settled well before the last tick
                    par_err_d = par_err;
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (last_s) begin
                    state_d      = S_IDLE;
                    data_valid_d = !stp_err && !(par_en_q && par_err_q);
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                par_en_d  = 1'b0;
                par_err_d = 1'b0;
            end
        endcase
    end

    // State and frame-status registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            par_en_q     <= 1'b0;
            par_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_en_q     <= par_en_d;
            par_err_q    <= par_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Counter enable and per-state strobes, decoded from the state register
    always_comb begin
        cnt_enable  = busy_s;
        dat_samp_en = busy_s && samp_win_s;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (state_q)
            S_START:  strt_chk_en = strobe_s;
            S_DATA:   deser_en    = strobe_s;
            S_PARITY: par_chk_en  = strobe_s;
            S_STOP:   stp_chk_en  = strobe_s;
            default: begin
                strt_chk_en = 1'b0;
                deser_en    = 1'b0;
                par_chk_en  = 1'b0;
                stp_chk_en  = 1'b0;
            end
        endcase
    end

    assign data_valid = data_valid_q;

endmodule
